// File: rtl/myo_spi_mon_pkg.sv
// myo_spi_mon_pkg: shared sizes, FIFO entry, monitor states and event bits (MYO_SPI_MON_MISO_EN adds the miso field)
package myo_spi_mon_pkg;

    localparam int WORD_BITS    = 16;
    localparam int NUM_SLAVES   = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int SLV_W        = $clog2(NUM_SLAVES);
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int BCNT_W       = $clog2(WORD_BITS);
    localparam int NUM_EVENTS   = 28;
    localparam int EV_OVERFLOW  = 8;
    localparam int EV_PROTO_ERR = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ABORT
    } mon_state_t;

    typedef struct packed {
        logic [WORD_BITS-1:0] mosi;
`ifdef MYO_SPI_MON_MISO_EN
        logic [WORD_BITS-1:0] miso;
`endif
        logic [SLV_W-1:0]     slave;
        logic                 last;
    } mon_entry_t;

    // Index of the set bit in a one-hot select vector
    function automatic logic [SLV_W-1:0] onehot_idx(input logic [NUM_SLAVES-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (v[i]) onehot_idx = SLV_W'(i);
    endfunction

endpackage

// File: rtl/myo_spi_mon_fifo.sv
// myo_spi_mon_fifo: show-ahead synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle
module myo_spi_mon_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          w_pop, w_push, w_full;

    assign w_full   = r_count == (AW+1)'(DEPTH);
    assign w_pop    = pop && r_count != '0;
    assign w_push   = push && (!w_full || w_pop);
    assign drop     = push && !w_push;
    assign rd_valid = r_count != '0;
    assign rd_data  = rd_valid ? r_mem[r_rd] : '0;
    assign count    = r_count;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= push_data;
    end

endmodule

// File: rtl/myo_spi_monitor.sv
// myo_spi_monitor: passive myocontrol SPI sniffer feeding a debug FIFO and STM event pulses; define MYO_SPI_MON_MISO_EN to capture miso
module myo_spi_monitor
    import myo_spi_mon_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_miso,
    input  logic [NUM_SLAVES-1:0] spi_ss_n,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [WORD_BITS-1:0]  rd_mosi,
    output logic [WORD_BITS-1:0]  rd_miso,
    output logic [SLV_W-1:0]      rd_slave,
    output logic                  rd_last,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  overflow,
    output logic                  proto_err,
    input  logic                  clear_flags,
    output logic [NUM_EVENTS-1:0] stm_hwevents
);

    logic [2:0]            r_sck_s;
    logic [1:0]            r_mosi_s;
    logic [NUM_SLAVES-1:0] r_ss_s0, r_ss_s1;
    mon_state_t            r_state;
    logic [SLV_W-1:0]      r_slave, r_push_slave;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [WORD_BITS-1:0]  r_sh_mosi, r_stg_mosi, r_push_mosi;
    logic                  r_stg_valid, r_push, r_push_last;
    logic [NUM_EVENTS-1:0] r_ev;
    logic                  r_overflow, r_proto_err;
    logic [NUM_SLAVES-1:0] w_sel;
    logic [WORD_BITS-1:0]  w_mosi_word;
    logic                  w_sck_rise, w_none, w_multi, w_one, w_in_shift;
    logic                  w_end, w_shift, w_word_done, w_abort, w_drop;
    mon_entry_t            w_push_entry, w_head;

    // Bus synchronisers; selects come out of reset as "all low" so the monitor waits for an idle bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_s  <= '0;
            r_mosi_s <= '0;
            r_ss_s0  <= '0;
            r_ss_s1  <= '0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], spi_sck};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_ss_s0  <= spi_ss_n;
            r_ss_s1  <= r_ss_s0;
        end
    end

    assign w_sck_rise  = r_sck_s[1] && !r_sck_s[2];
    assign w_sel       = ~r_ss_s1;
    assign w_none      = w_sel == '0;
    assign w_multi     = (w_sel & (w_sel - 1'b1)) != '0;
    assign w_one       = !w_none && !w_multi;
    assign w_in_shift  = r_state == ST_SHIFT;
    assign w_end       = w_in_shift && w_none;
    assign w_shift     = w_in_shift && w_one && w_sck_rise;
    assign w_word_done = w_shift && r_bcnt == BCNT_W'(WORD_BITS - 1);
    assign w_abort     = r_state != ST_ABORT && w_multi;
    assign w_mosi_word = {r_sh_mosi[WORD_BITS-2:0], r_mosi_s[1]};

`ifdef MYO_SPI_MON_MISO_EN
    logic [1:0]           r_miso_s;
    logic [WORD_BITS-1:0] r_sh_miso, r_stg_miso, r_push_miso, w_miso_word;

    assign w_miso_word = {r_sh_miso[WORD_BITS-2:0], r_miso_s[1]};

    // miso capture path, mirroring the mosi shift/stage/push timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_miso_s    <= '0;
            r_sh_miso   <= '0;
            r_stg_miso  <= '0;
            r_push_miso <= '0;
        end else begin
            r_miso_s <= {r_miso_s[0], spi_miso};
            if (w_shift) r_sh_miso <= w_miso_word;
            if (w_word_done) r_stg_miso <= w_miso_word;
            if (w_end || w_word_done) r_push_miso <= r_stg_miso;
        end
    end

    assign rd_miso = w_head.miso;
`else
    logic w_unused_miso;

    assign w_unused_miso = spi_miso;
    assign rd_miso       = '0;
`endif

    // Assemble the FIFO entry from the registered push fields
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.mosi  = r_push_mosi;
        w_push_entry.slave = r_push_slave;
        w_push_entry.last  = r_push_last;
`ifdef MYO_SPI_MON_MISO_EN
        w_push_entry.miso  = r_push_miso;
`endif
    end

    // Frame FSM with deserialiser, staging register, push request, sticky flags and event pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ABORT;
            r_slave      <= '0;
            r_bcnt       <= '0;
            r_sh_mosi    <= '0;
            r_stg_mosi   <= '0;
            r_stg_valid  <= 1'b0;
            r_push       <= 1'b0;
            r_push_mosi  <= '0;
            r_push_slave <= '0;
            r_push_last  <= 1'b0;
            r_ev         <= '0;
            r_overflow   <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_multi) r_state <= ST_ABORT;
                    else if (w_one) begin
                        r_state <= ST_SHIFT;
                        r_slave <= onehot_idx(w_sel);
                        r_bcnt  <= '0;
                    end
                end
                ST_SHIFT: r_state <= w_multi ? ST_ABORT : w_none ? ST_IDLE : ST_SHIFT;
                default:  r_state <= w_none ? ST_IDLE : ST_ABORT;
            endcase
            if (w_shift) begin
                r_sh_mosi <= w_mosi_word;
                r_bcnt    <= r_bcnt + 1'b1;
            end
            if (w_word_done) r_stg_mosi <= w_mosi_word;
            r_stg_valid <= w_in_shift && w_one && (r_stg_valid || w_word_done);
            r_push      <= r_stg_valid && (w_end || w_word_done);
            if (w_end || w_word_done) begin
                r_push_mosi  <= r_stg_mosi;
                r_push_slave <= r_slave;
                r_push_last  <= w_end;
            end
            r_ev              <= '0;
            r_ev[EV_OVERFLOW] <= w_drop;
            if (w_end && r_stg_valid) r_ev[r_slave] <= 1'b1;
            if (w_abort || (w_end && r_bcnt != '0)) r_ev[EV_PROTO_ERR] <= 1'b1;
            r_overflow  <= w_drop || (r_overflow && !clear_flags);
            r_proto_err <= w_abort || (w_end && r_bcnt != '0) || (r_proto_err && !clear_flags);
        end
    end

    myo_spi_mon_fifo #(
        .DW    ($bits(mon_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (r_push),
        .push_data (w_push_entry),
        .pop       (rd_en),
        .rd_data   (w_head),
        .rd_valid  (rd_valid),
        .count     (fifo_count),
        .drop      (w_drop)
    );

    assign rd_mosi      = w_head.mosi;
    assign rd_slave     = w_head.slave;
    assign rd_last      = w_head.last;
    assign overflow     = r_overflow;
    assign proto_err    = r_proto_err;
    assign stm_hwevents = r_ev;

endmodule

// File: tb/tb_myo_spi_monitor.sv
// tb_myo_spi_monitor: directed bench for the SPI monitor FIFO, flags and STM events
`timescale 1ns/1ps
module tb_myo_spi_monitor;
    import myo_spi_mon_pkg::*;

`ifdef MYO_SPI_MON_MISO_EN
    localparam bit MISO_ON = 1'b1;
`else
    localparam bit MISO_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  spi_sck = 1'b0;
    logic                  spi_mosi = 1'b0;
    logic                  spi_miso = 1'b0;
    logic [NUM_SLAVES-1:0] spi_ss_n = '1;
    logic                  rd_en = 1'b0;
    logic                  clear_flags = 1'b0;
    logic                  rd_valid, rd_last, overflow, proto_err;
    logic [WORD_BITS-1:0]  rd_mosi, rd_miso;
    logic [SLV_W-1:0]      rd_slave;
    logic [CNT_W-1:0]      fifo_count;
    logic [NUM_EVENTS-1:0] stm_hwevents;

    int n_chk = 0;
    int n_pass = 0;
    int ev_cnt [NUM_EVENTS] = '{default: 0};
    int ev_base[NUM_EVENTS] = '{default: 0};

    myo_spi_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_ss_n     (spi_ss_n),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_mosi      (rd_mosi),
        .rd_miso      (rd_miso),
        .rd_slave     (rd_slave),
        .rd_last      (rd_last),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .proto_err    (proto_err),
        .clear_flags  (clear_flags),
        .stm_hwevents (stm_hwevents)
    );

    always #5 clk = ~clk;

    // Count high cycles per event bit (reads the value held through the cycle just ending)
    always @(posedge clk)
        for (int i = 0; i < NUM_EVENTS; i++)
            if (stm_hwevents[i]) ev_cnt[i]++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic snap();
        ev_base = ev_cnt;
    endtask

    function automatic int evd(input int i);
        return ev_cnt[i] - ev_base[i];
    endfunction

    task automatic spi_bits(input logic [15:0] mo, input logic [15:0] mi, input int n);
        for (int b = 15; b > 15 - n; b--) begin
            spi_mosi = mo[b];
            spi_miso = mi[b];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame_start(input int s);
        spi_ss_n = ~(NUM_SLAVES'(1) << s);
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        spi_ss_n = '1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] mo, input logic [15:0] mi,
                             input logic [2:0] sl, input logic la);
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_mosi"}, rd_mosi, mo);
        chk({tag, "_miso"}, rd_miso, MISO_ON ? mi : 16'h0);
        chk({tag, "_slave"}, rd_slave, sl);
        chk({tag, "_last"}, rd_last, la);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] w;
        logic        seen;
        int          hi;
        repeat (3) @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_ev", stm_hwevents, 0);
        chk("rst_mosi", rd_mosi, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        snap();
        frame_start(3);
        spi_bits(16'hA55A, 16'h0F0F, 16);
        spi_bits(16'h1234, 16'hFFFF, 16);
        frame_end();
        chk("t1_count", fifo_count, 2);
        chk("t1_ev3", evd(3), 1);
        chk("t1_ev9", evd(9), 0);
        chk("t1_perr", proto_err, 0);
        pop_check("t1_w0", 16'hA55A, 16'h0F0F, 3, 0);
        pop_check("t1_w1", 16'h1234, 16'hFFFF, 3, 1);
        chk("t1_empty", fifo_count, 0);

        snap();
        spi_ss_n = 8'b1111_1100;
        repeat (4) @(negedge clk);
        spi_bits(16'hFFFF, 16'hFFFF, 16);
        frame_end();
        chk("t2_count", fifo_count, 0);
        chk("t2_perr", proto_err, 1);
        chk("t2_ev9", evd(9), 1);
        chk("t2_ev0", evd(0), 0);
        clear();
        chk("t2_clr", proto_err, 0);

        snap();
        frame_start(0);
        spi_bits(16'hBEEF, 16'h5555, 16);
        spi_bits(16'hA800, 16'h5000, 5);
        frame_end();
        chk("t3_count", fifo_count, 1);
        chk("t3_perr", proto_err, 1);
        chk("t3_ev9", evd(9), 1);
        chk("t3_ev0", evd(0), 1);
        pop_check("t3_w0", 16'hBEEF, 16'h5555, 0, 1);
        clear();

        snap();
        frame_start(5);
        for (int i = 0; i < 17; i++) begin
            w = 16'(16'h0500 + i);
            spi_bits(w, ~w, 16);
        end
        frame_end();
        chk("t4_count", fifo_count, 16);
        chk("t4_ovf", overflow, 1);
        chk("t4_ev8", evd(8), 1);
        chk("t4_ev5", evd(5), 1);
        for (int i = 0; i < 16; i++) begin
            w = 16'(16'h0500 + i);
            pop_check($sformatf("t4_p%0d", i), w, ~w, 5, 0);
        end
        chk("t4_empty", fifo_count, 0);
        clear();
        chk("t4_clr", overflow, 0);

        snap();
        frame_start(2);
        for (int i = 0; i < 16; i++) begin
            w = 16'(16'h0200 + i);
            spi_bits(w, ~w, 16);
        end
        frame_end();
        chk("t5_full", fifo_count, 16);
        chk("t5_ovf0", overflow, 0);
        frame_start(4);
        spi_bits(16'h4444, 16'hBBBB, 16);
        repeat (4) @(negedge clk);
        spi_ss_n = '1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = stm_hwevents[4];
        end
        chk("t5_evwait", seen, 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_count", fifo_count, 16);
        chk("t5_ovf", overflow, 0);
        chk("t5_ev8", evd(8), 0);
        for (int i = 1; i < 16; i++) begin
            w = 16'(16'h0200 + i);
            pop_check($sformatf("t5_p%0d", i), w, ~w, 2, i == 15);
        end
        pop_check("t5_new", 16'h4444, 16'hBBBB, 4, 1);

        frame_start(7);
        spi_bits(16'h7777, 16'h8888, 16);
        frame_end();
        spi_ss_n = 8'h3F;
        repeat (8) @(negedge clk);
        spi_ss_n = '1;
        repeat (8) @(negedge clk);
        chk("t6_pre_count", fifo_count, 1);
        chk("t6_pre_perr", proto_err, 1);
        frame_start(6);
        spi_bits(16'h6666, 16'h9999, 8);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_perr", proto_err, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_mosi", rd_mosi, 0);
        chk("t6_rst_slave", rd_slave, 0);
        chk("t6_rst_ev", stm_hwevents, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        snap();
        spi_bits(16'h6666, 16'h9999, 8);
        spi_bits(16'h1357, 16'h2468, 16);
        frame_end();
        chk("t6_count", fifo_count, 0);
        chk("t6_perr", proto_err, 0);
        chk("t6_ev6", evd(6), 0);
        chk("t6_ev9", evd(9), 0);
        frame_start(1);
        spi_bits(16'hC3C3, 16'h3C3C, 16);
        frame_end();
        chk("t6_ev1", evd(1), 1);
        pop_check("t6_w0", 16'hC3C3, 16'h3C3C, 1, 1);
        chk("t6_empty", fifo_count, 0);

        hi = 0;
        for (int i = 10; i < NUM_EVENTS; i++) hi += ev_cnt[i];
        chk("ev_hi_zero", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
